board_draw_ctrl: RTL and testbench

Memory-mapped draw engine for the two BattleChip boards on the 320x240 VGA framebuffer.
- The CPU stages square commands (x, y, attack type, player) through a byte register interface. Commands are queued in a FIFO and rasterised one pixel per clock onto the vga_adapter plot port.
- Generalises the single-shot screen drawer: parametrised grid, cell size, board origins and queue depth; clear-on-command; readable status with sticky error flags.

---
 rtl/board_draw_pkg.sv | 45 ++++
 rtl/rect_raster.sv | 101 ++++++++++
 rtl/board_draw_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_board_draw_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/board_draw_pkg.sv
// Shared types and constants for the BattleChip board draw engine.
package board_draw_pkg;

   typedef enum logic [1:0] {
      WATER = 2'd0,
      MISS  = 2'd1,
      HIT   = 2'd2,
      SUNK  = 2'd3
   } attack_t;

   localparam logic [2:0] COL_WATER = 3'b001;
   localparam logic [2:0] COL_MISS  = 3'b111;
   localparam logic [2:0] COL_HIT   = 3'b100;
   localparam logic [2:0] COL_SUNK  = 3'b110;

   localparam logic [2:0] REG_X      = 3'd0;
   localparam logic [2:0] REG_Y      = 3'd1;
   localparam logic [2:0] REG_TYPE   = 3'd2;
   localparam logic [2:0] REG_COMMIT = 3'd3;
   localparam logic [2:0] REG_CLEAR  = 3'd4;
   localparam logic [2:0] REG_STATUS = 3'd5;

   localparam int unsigned ST_IDLE   = 0;
   localparam int unsigned ST_FULL   = 1;
   localparam int unsigned ST_OVF    = 2;
   localparam int unsigned ST_RANGE  = 3;
   localparam int unsigned ST_CNT_LO = 4;

   typedef struct packed {
      logic       player;
      logic [3:0] x;
      logic [3:0] y;
      attack_t    kind;
   } cmd_t;

   function automatic logic [2:0] colour_of(input attack_t t);
      case (t)
         WATER:   return COL_WATER;
         MISS:    return COL_MISS;
         HIT:     return COL_HIT;
         default: return COL_SUNK;
      endcase
   endfunction

endpackage

// File: rtl/rect_raster.sv
// Rasterises a w x h rectangle one pixel per clock, row-major, x fastest.
// The first pixel is emitted on the start cycle itself; done pulses with the last pixel.
module rect_raster (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [8:0] x0_i,
   input  logic [7:0] y0_i,
   input  logic [9:0] w_i,
   input  logic [8:0] h_i,
   input  logic [2:0] colour_i,
   output logic [8:0] vga_x_o,
   output logic [7:0] vga_y_o,
   output logic [2:0] colour_o,
   output logic       plot_o,
   output logic       done_o
);

   logic       busy_q, busy_d;
   logic [8:0] x0_q, x0_d, xl_q, xl_d, cx_q, cx_d, vx_q, vx_d;
   logic [7:0] y0_q, y0_d, yl_q, yl_d, cy_q, cy_d, vy_q, vy_d;
   logic [2:0] col_q, col_d, vc_q, vc_d;
   logic       plot_q, plot_d, done_q, done_d;
   logic [8:0] cx;
   logic [7:0] cy;
   logic       act, last_col;

   always_comb begin
      x0_d   = start_i ? x0_i : x0_q;
      y0_d   = start_i ? y0_i : y0_q;
      xl_d   = start_i ? 9'(w_i - 10'd1) : xl_q;
      yl_d   = start_i ? 8'(h_i - 9'd1) : yl_q;
      col_d  = start_i ? colour_i : col_q;
      cx     = start_i ? '0 : cx_q;
      cy     = start_i ? '0 : cy_q;
      act    = start_i | busy_q;
      last_col = (cx == xl_d);
      busy_d = busy_q;
      cx_d   = cx_q;
      cy_d   = cy_q;
      vx_d   = vx_q;
      vy_d   = vy_q;
      vc_d   = vc_q;
      plot_d = 1'b0;
      done_d = 1'b0;
      if (act) begin
         vx_d   = x0_d + cx;
         vy_d   = y0_d + cy;
         vc_d   = col_d;
         plot_d = 1'b1;
         done_d = last_col && (cy == yl_d);
         busy_d = !(last_col && (cy == yl_d));
         if (last_col) begin
            cx_d = '0;
            cy_d = cy + 8'd1;
         end else begin
            cx_d = cx + 9'd1;
            cy_d = cy;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         x0_q   <= '0;
         y0_q   <= '0;
         xl_q   <= '0;
         yl_q   <= '0;
         col_q  <= '0;
         cx_q   <= '0;
         cy_q   <= '0;
         vx_q   <= '0;
         vy_q   <= '0;
         vc_q   <= '0;
         plot_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         x0_q   <= x0_d;
         y0_q   <= y0_d;
         xl_q   <= xl_d;
         yl_q   <= yl_d;
         col_q  <= col_d;
         cx_q   <= cx_d;
         cy_q   <= cy_d;
         vx_q   <= vx_d;
         vy_q   <= vy_d;
         vc_q   <= vc_d;
         plot_q <= plot_d;
         done_q <= done_d;
      end
   end

   assign vga_x_o  = vx_q;
   assign vga_y_o  = vy_q;
   assign colour_o = vc_q;
   assign plot_o   = plot_q;
   assign done_o   = done_q;

endmodule

// File: rtl/board_draw_ctrl.sv
// Register-mapped draw engine: queues square commands and rasterises them, or a
// full-screen clear, onto the vga_adapter plot port.
module board_draw_ctrl
   import board_draw_pkg::*;
#(
   parameter int unsigned GRID_N     = 10,
   parameter int unsigned SQ_PX      = 8,
   parameter int unsigned SCR_W      = 320,
   parameter int unsigned SCR_H      = 240,
   parameter int unsigned X0_L       = 10,
   parameter int unsigned X0_R       = 170,
   parameter int unsigned Y0         = 40,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [2:0] addr,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [8:0] VGA_X,
   output logic [7:0] VGA_Y,
   output logic [2:0] VGA_COLOUR,
   output logic       VGA_PLOT
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   if (X0_L + GRID_N * SQ_PX > SCR_W || X0_R + GRID_N * SQ_PX > SCR_W ||
       Y0 + GRID_N * SQ_PX > SCR_H || SCR_W > 511 || SCR_H > 255 ||
       GRID_N > 16 || SQ_PX < 2 || FIFO_DEPTH < 2 || FIFO_DEPTH > 15 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("board_draw_ctrl: board geometry or queue depth out of range");
   end

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_POP, S_PAINT} state_t;

   state_t      state_q, state_d;
   logic        boot_q;
   logic [3:0]  stg_x_q, stg_y_q;
   attack_t     stg_type_q;
   cmd_t        fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [3:0]  count_q;
   logic        clr_pend_q, clr_pend_d, ovf_q, rng_q;
   logic [7:0]  data_out_q, status;

   logic wr_commit, wr_clear, wr_status, range_bad, full, push, pop;
   logic rs_start, rs_clear, rs_done;
   logic [8:0] rs_x0, ox;
   logic [7:0] rs_y0, oy;
   logic [9:0] rs_w;
   logic [8:0] rs_h;
   logic [2:0] rs_col;
   cmd_t new_cmd, head;
   logic unused_data;

   assign unused_data = ^data_in[7:4];

   assign wr_commit = wr_en && (addr == REG_COMMIT);
   assign wr_clear  = wr_en && (addr == REG_CLEAR);
   assign wr_status = wr_en && (addr == REG_STATUS);
   assign range_bad = (5'(stg_x_q) >= 5'(GRID_N)) || (5'(stg_y_q) >= 5'(GRID_N));
   assign full      = (count_q == 4'(FIFO_DEPTH));
   assign push      = wr_commit && !range_bad && !full;
   assign pop       = (state_q == S_POP);
   assign new_cmd   = '{player: data_in[0], x: stg_x_q, y: stg_y_q, kind: stg_type_q};
   assign head      = fifo_q[rd_ptr_q];

   assign ox = (head.player ? 9'(X0_R) : 9'(X0_L)) + 9'(head.x) * 9'(SQ_PX);
   assign oy = 8'(Y0) + 8'(head.y) * 8'(SQ_PX);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stg_x_q    <= '0;
         stg_y_q    <= '0;
         stg_type_q <= WATER;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         rng_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         if (wr_en && addr == REG_X)    stg_x_q    <= data_in[3:0];
         if (wr_en && addr == REG_Y)    stg_y_q    <= data_in[3:0];
         if (wr_en && addr == REG_TYPE) stg_type_q <= attack_t'(data_in[1:0]);
         // Flush beats any pop issued in the same cycle.
         if (wr_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 4'd1;
            else if (pop && !push) count_q <= count_q - 4'd1;
         end
         if (wr_commit && range_bad)      rng_q <= 1'b1;
         else if (wr_status && data_in[3]) rng_q <= 1'b0;
         if (wr_commit && !range_bad && full) ovf_q <= 1'b1;
         else if (wr_status && data_in[2])   ovf_q <= 1'b0;
         if (rd_en) data_out_q <= (addr == REG_STATUS) ? status : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= new_cmd;
   end

   always_comb begin
      status                       = '0;
      status[ST_IDLE]              = (state_q == S_IDLE) && (count_q == '0);
      status[ST_FULL]              = full;
      status[ST_OVF]               = ovf_q;
      status[ST_RANGE]             = rng_q;
      status[ST_CNT_LO +: 4]       = count_q;
   end

   always_comb begin
      state_d  = state_q;
      rs_start = 1'b0;
      rs_clear = 1'b0;
      case (state_q)
         S_CLEAR: begin
            if (boot_q) begin
               rs_start = 1'b1;
               rs_clear = 1'b1;
            end else if (rs_done) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (clr_pend_q || wr_clear) begin
               state_d  = S_CLEAR;
               rs_start = 1'b1;
               rs_clear = 1'b1;
            end else if (count_q != '0) begin
               state_d = S_POP;
            end
         end
         S_POP: begin
            rs_start = 1'b1;
            state_d  = S_PAINT;
         end
         default: begin
            if (rs_done) state_d = S_IDLE;
         end
      endcase

      // A running clear absorbs requests; otherwise they wait for IDLE.
      clr_pend_d = clr_pend_q;
      if (wr_clear && state_q != S_CLEAR) clr_pend_d = 1'b1;
      if (state_q == S_IDLE && state_d == S_CLEAR) clr_pend_d = 1'b0;

      if (rs_clear) begin
         rs_x0  = '0;
         rs_y0  = '0;
         rs_w   = 10'(SCR_W);
         rs_h   = 9'(SCR_H);
         rs_col = BG_COLOUR;
      end else begin
         rs_x0  = ox + 9'd1;
         rs_y0  = oy + 8'd1;
         rs_w   = 10'(SQ_PX - 1);
         rs_h   = 9'(SQ_PX - 1);
         rs_col = colour_of(head.kind);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_CLEAR;
         boot_q     <= 1'b1;
         clr_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_q     <= 1'b0;
         clr_pend_q <= clr_pend_d;
      end
   end

   rect_raster u_raster (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .start_i  (rs_start),
      .x0_i     (rs_x0),
      .y0_i     (rs_y0),
      .w_i      (rs_w),
      .h_i      (rs_h),
      .colour_i (rs_col),
      .vga_x_o  (VGA_X),
      .vga_y_o  (VGA_Y),
      .colour_o (VGA_COLOUR),
      .plot_o   (VGA_PLOT),
      .done_o   (rs_done)
   );

   assign data_out = data_out_q;

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Directed bench for board_draw_ctrl: square table, queue overflow, range drop,
// clear during paint and reset during paint, all checked against a pixel log.
module tb_board_draw_ctrl;

   localparam int SW = 256;
   localparam int SH = 128;

   logic       clock, reset_n, wr_en, rd_en, VGA_PLOT;
   logic [2:0] addr, VGA_COLOUR;
   logic [7:0] data_in, data_out, VGA_Y;
   logic [8:0] VGA_X;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {int x; int y; int c;} pix_t;
   pix_t pix_q[$];

   typedef struct {
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] ty;
      logic       pl;
      int         ex;
      int         ey;
      int         col;
   } vec_t;
   vec_t tbl[5];

   board_draw_ctrl #(.SCR_W(SW), .SCR_H(SH)) dut (
      .clock(clock), .reset_n(reset_n), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
      .data_in(data_in), .data_out(data_out), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
      .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock)
      if (reset_n === 1'b1 && VGA_PLOT === 1'b1)
         pix_q.push_back('{int'(VGA_X), int'(VGA_Y), int'(VGA_COLOUR)});

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clock);
      addr = a; data_in = d; wr_en = 1'b1;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] v);
      @(negedge clock);
      addr = a; rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      v = data_out;
   endtask

   task automatic commit(input vec_t v);
      wr(3'd0, {4'h0, v.x});
      wr(3'd1, {4'h0, v.y});
      wr(3'd2, {6'h0, v.ty});
      wr(3'd3, {7'h0, v.pl});
   endtask

   task automatic wait_pix(input int n, input int budget);
      int k = 0;
      while (pix_q.size() < n && k < budget) begin
         @(negedge clock);
         k++;
      end
   endtask

   task automatic check_rect(input string nm, input int x0, input int y0,
                             input int w, input int h, input int col);
      int n = w * h;
      int got, errs;
      pix_t p;
      wait_pix(n, n + 300);
      got  = (pix_q.size() < n) ? pix_q.size() : n;
      errs = 0;
      for (int i = 0; i < got; i++) begin
         p = pix_q.pop_front();
         if (p.x != x0 + i % w || p.y != y0 + i / w || p.c != col) errs++;
      end
      chk({nm, " pixel count"}, got, n);
      chk({nm, " bad pixels"}, errs, 0);
   endtask

   task automatic wait_idle(input string nm);
      logic [7:0] s = 8'h00;
      for (int k = 0; k < 400 && s[0] !== 1'b1; k++) rd(3'd5, s);
      chk({nm, " idle reached"}, int'(s[0]), 1);
   endtask

   initial begin
      logic [7:0] s;
      vec_t bad;
      tbl[0] = '{x:4'd2, y:4'd3, ty:2'd2, pl:1'b1, ex:187, ey:65,  col:3'b100};
      tbl[1] = '{x:4'd0, y:4'd0, ty:2'd0, pl:1'b0, ex:11,  ey:41,  col:3'b001};
      tbl[2] = '{x:4'd9, y:4'd9, ty:2'd3, pl:1'b1, ex:243, ey:113, col:3'b110};
      tbl[3] = '{x:4'd9, y:4'd0, ty:2'd1, pl:1'b0, ex:83,  ey:41,  col:3'b111};
      tbl[4] = '{x:4'd5, y:4'd7, ty:2'd2, pl:1'b0, ex:51,  ey:97,  col:3'b100};

      reset_n = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      repeat (3) @(negedge clock);
      chk("reset VGA_PLOT", int'(VGA_PLOT), 0);
      chk("reset VGA_X", int'(VGA_X), 0);
      chk("reset VGA_Y", int'(VGA_Y), 0);
      chk("reset VGA_COLOUR", int'(VGA_COLOUR), 0);
      chk("reset data_out", int'(data_out), 0);
      reset_n = 1'b1;

      // Five commits during the power-up clear: queue fills, fifth overflows.
      for (int i = 0; i < 5; i++) commit(tbl[i]);
      rd(3'd5, s);
      chk("status full+ovf", int'(s), 8'h46);
      wr(3'd5, 8'h04);
      rd(3'd5, s);
      chk("status ovf cleared", int'(s), 8'h42);
      check_rect("boot clear", 0, 0, SW, SH, 0);
      for (int i = 0; i < 4; i++)
         check_rect($sformatf("queued sq%0d", i), tbl[i].ex, tbl[i].ey, 7, 7, tbl[i].col);
      wait_idle("after burst");
      rd(3'd5, s);
      chk("status idle", int'(s), 8'h01);

      for (int i = 0; i < 5; i++) begin
         commit(tbl[i]);
         check_rect($sformatf("table sq%0d", i), tbl[i].ex, tbl[i].ey, 7, 7, tbl[i].col);
      end
      repeat (10) @(negedge clock);
      chk("no stray pixels", pix_q.size(), 0);

      bad = '{x:4'd10, y:4'd0, ty:2'd1, pl:1'b0, ex:0, ey:0, col:0};
      commit(bad);
      rd(3'd5, s);
      chk("status range", int'(s), 8'h09);
      repeat (60) @(negedge clock);
      chk("range nothing drawn", pix_q.size(), 0);
      wr(3'd5, 8'h08);
      rd(3'd5, s);
      chk("status range cleared", int'(s), 8'h01);
      wr(3'd0, 8'h05);
      chk("data_out holds", int'(data_out), 8'h01);
      rd(3'd0, s);
      chk("read other addr", int'(s), 0);

      // Clear written while the first of three squares is painting.
      commit(tbl[0]);
      commit(tbl[1]);
      commit(tbl[2]);
      wait_pix(10, 200);
      wr(3'd4, 8'h01);
      rd(3'd5, s);
      chk("status flushed", int'(s), 8'h00);
      check_rect("sq before clear", tbl[0].ex, tbl[0].ey, 7, 7, tbl[0].col);
      check_rect("requested clear", 0, 0, SW, SH, 0);
      repeat (100) @(negedge clock);
      chk("flushed never drawn", pix_q.size(), 0);
      wait_idle("after clear");
      rd(3'd5, s);
      chk("status after clear", int'(s), 8'h01);

      // Asynchronous reset in the middle of a square.
      commit(tbl[2]);
      wait_pix(5, 200);
      #2 reset_n = 1'b0;
      #1;
      chk("async rst VGA_PLOT", int'(VGA_PLOT), 0);
      chk("async rst VGA_X", int'(VGA_X), 0);
      chk("async rst VGA_Y", int'(VGA_Y), 0);
      chk("async rst VGA_COLOUR", int'(VGA_COLOUR), 0);
      chk("async rst data_out", int'(data_out), 0);
      pix_q.delete();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      check_rect("restart clear", 0, 0, SW, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
